// File: rtl/input_feed_scheduler.sv
// Skewed read sequencer for the systolic array input FIFOs: row i is read for
// len_q consecutive schedule steps starting at step i; any empty active row freezes the wavefront.
module input_feed_scheduler #(
   parameter int NUM_ROWS = 16,
   parameter int LEN_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [LEN_W-1:0]    tile_len,
   input  logic                abort,
   input  logic [NUM_ROWS-1:0] fifo_empty,
   output logic [NUM_ROWS-1:0] fifo_rd_en,
   output logic [NUM_ROWS-1:0] row_valid,
   output logic                busy,
   output logic                done,
   output logic [15:0]         stall_cnt
);

   localparam int CYC_W = LEN_W + 5;

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      FIN
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    len_nxt;
   logic [CYC_W-1:0]    cyc;
   logic [CYC_W-1:0]    cyc_nxt;
   logic [15:0]         stall_nxt;
   logic [NUM_ROWS-1:0] active;
   logic [NUM_ROWS-1:0] rd_en;
   logic                stall;
   logic                last;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Row is active for schedule steps row .. row+len-1 (upper bound kept exclusive).
   function automatic logic row_active(input logic [CYC_W-1:0] c,
                                       input logic [LEN_W-1:0] len,
                                       input int               row);
      logic [CYC_W-1:0] lo;
      logic [CYC_W-1:0] hi;
      lo = CYC_W'(row);
      hi = lo + CYC_W'(len);
      return (c >= lo) && (c < hi);
   endfunction

   always_comb begin
      active = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         active[i] = row_active(cyc, len_q, i);
      end
   end

   assign stall = |(active & fifo_empty);
   assign last  = (cyc == CYC_W'(len_q) + CYC_W'(NUM_ROWS - 2));

   always_comb begin
      state_nxt = state;
      len_nxt   = len_q;
      cyc_nxt   = cyc;
      stall_nxt = stall_cnt;
      rd_en     = '0;
      case (state)
         IDLE: begin
            if (start) begin
               cyc_nxt   = '0;
               stall_nxt = '0;
               if (tile_len != '0) begin
                  len_nxt   = tile_len;
                  state_nxt = FEED;
               end else begin
                  state_nxt = FIN;
               end
            end
         end
         FEED: begin
            // abort outranks both the stall freeze and the completion check
            if (abort) begin
               state_nxt = FIN;
            end else if (stall) begin
               stall_nxt = sat_inc16(stall_cnt);
            end else begin
               rd_en   = active;
               cyc_nxt = cyc + CYC_W'(1);
               if (last) begin
                  state_nxt = FIN;
               end
            end
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      fifo_rd_en = rd_en;
      busy       = (state != IDLE);
      done       = (state == FIN);
   end

   // Registered state; row_valid trails the read enables by the FIFO read latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         len_q     <= '0;
         cyc       <= '0;
         stall_cnt <= '0;
         row_valid <= '0;
      end else begin
         state     <= state_nxt;
         len_q     <= len_nxt;
         cyc       <= cyc_nxt;
         stall_cnt <= stall_nxt;
         row_valid <= rd_en;
      end
   end

endmodule

// File: tb/tb_input_feed_scheduler.sv
// Directed bench for input_feed_scheduler: basic, stalled, inactive-empty, zero/max length,
// abort with ignored start, and mid-feed reset.
module tb_input_feed_scheduler;

   localparam int NR = 16;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [LW-1:0] tile_len;
   logic          abort;
   logic [NR-1:0] fifo_empty;
   logic [NR-1:0] fifo_rd_en;
   logic [NR-1:0] row_valid;
   logic          busy;
   logic          done;
   logic [15:0]   stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   input_feed_scheduler #(.NUM_ROWS(NR), .LEN_W(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .tile_len  (tile_len),
      .abort     (abort),
      .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en),
      .row_valid (row_valid),
      .busy      (busy),
      .done      (done),
      .stall_cnt (stall_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NR-1:0] exp_mask(input int w, input int len);
      logic [NR-1:0] m;
      m = '0;
      for (int i = 0; i < NR; i++) m[i] = (w >= i) && (w <= i + len - 1);
      return m;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Launches a feed from IDLE and follows it to IDLE. Unused options take -1.
   task automatic run_feed(input string name, input int len,
                           input int st_row, input int st_from, input int st_len,
                           input int ie_row, input int ie_until,
                           input int abort_at, input int start_at,
                           input int exp_cycles, input int exp_stalls);
      int            w;
      int            k;
      int            stalls_left;
      int            bad;
      int            reads[NR];
      logic [NR-1:0] exp_rd;
      logic [NR-1:0] prev_rd;
      bit            finished;
      bit            aborted;
      bit            stalling;
      start      = 1'b1;
      tile_len   = LW'(len);
      abort      = 1'b0;
      fifo_empty = '0;
      #1;
      check($sformatf("%s_idle_busy", name), busy, 0);
      w = 0; k = 0; stalls_left = st_len; prev_rd = '0;
      finished = 0; aborted = 0;
      for (int i = 0; i < NR; i++) reads[i] = 0;
      while (!finished && k < 400) begin
         step();
         start      = (k == start_at);
         tile_len   = 8'd2;
         abort      = (k == abort_at);
         fifo_empty = '0;
         stalling   = (w == st_from) && (stalls_left > 0);
         if (stalling) fifo_empty[st_row] = 1'b1;
         if (k < ie_until) fifo_empty[ie_row] = 1'b1;
         #1;
         check($sformatf("%s_busy_k%0d", name, k), busy, 1);
         check($sformatf("%s_done_k%0d", name, k), done, 0);
         check($sformatf("%s_rowvalid_k%0d", name, k), row_valid, prev_rd);
         check($sformatf("%s_rd_on_empty_k%0d", name, k), fifo_rd_en & fifo_empty, 0);
         if (k == 0) check($sformatf("%s_stall_clr", name), stall_cnt, 0);
         if (abort) begin
            exp_rd = '0; aborted = 1; finished = 1;
         end else if (stalling) begin
            exp_rd = '0; stalls_left--;
         end else begin
            exp_rd = exp_mask(w, len);
            for (int i = 0; i < NR; i++) reads[i] += int'(exp_rd[i]);
            if (w == len + NR - 2) finished = 1;
            w++;
         end
         check($sformatf("%s_rd_en_k%0d", name, k), fifo_rd_en, exp_rd);
         prev_rd = exp_rd;
         k++;
      end
      check($sformatf("%s_feed_cycles", name), k, exp_cycles);
      // FIN: a start and an abort here must both be ignored
      step();
      start = 1'b1; tile_len = 8'd3; abort = 1'b1; fifo_empty = '0;
      #1;
      check($sformatf("%s_fin_done", name), done, 1);
      check($sformatf("%s_fin_busy", name), busy, 1);
      check($sformatf("%s_fin_rd", name), fifo_rd_en, 0);
      check($sformatf("%s_fin_rowvalid", name), row_valid, prev_rd);
      step();
      start = 1'b0; abort = 1'b0;
      #1;
      check($sformatf("%s_end_done", name), done, 0);
      check($sformatf("%s_end_busy", name), busy, 0);
      check($sformatf("%s_end_rowvalid", name), row_valid, 0);
      check($sformatf("%s_stall_cnt", name), stall_cnt, exp_stalls);
      step();
      #1;
      check($sformatf("%s_stall_hold", name), stall_cnt, exp_stalls);
      if (!aborted) begin
         bad = 0;
         for (int i = 0; i < NR; i++) if (reads[i] != len) bad++;
         check($sformatf("%s_rows_short", name), bad, 0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; tile_len = '0; fifo_empty = '0;
      step();
      start = 1'b1; tile_len = 8'd4;
      #1;
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_row_valid", row_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      step();
      check("rst_ignores_start", busy, 0);
      rst = 1'b0;

      run_feed("basic", 4, -1, -1, 0, 0, -1, -1, -1, 19, 0);
      run_feed("stall", 4, 5, 6, 3, 0, -1, -1, -1, 22, 3);
      run_feed("inact", 4, -1, -1, 0, 15, 15, -1, -1, 19, 0);

      start = 1'b1; tile_len = 8'd0;
      step();
      start = 1'b0;
      #1;
      check("zero_done", done, 1);
      check("zero_busy", busy, 1);
      check("zero_rd", fifo_rd_en, 0);
      step();
      #1;
      check("zero_end_done", done, 0);
      check("zero_end_busy", busy, 0);
      check("zero_row_valid", row_valid, 0);

      run_feed("abort", 6, -1, -1, 0, 0, -1, 7, 3, 8, 0);
      run_feed("maxlen", 255, -1, -1, 0, 0, -1, -1, -1, 270, 0);

      start = 1'b1; tile_len = 8'd4;
      for (int k = 0; k < 10; k++) begin
         step();
         start = 1'b0;
         #1;
         check($sformatf("prerst_rd_k%0d", k), fifo_rd_en, exp_mask(k, 4));
      end
      step();
      rst = 1'b1;
      #1;
      check("midrst_rd", fifo_rd_en, 0);
      check("midrst_row_valid", row_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_stall_cnt", stall_cnt, 0);
      step();
      #1;
      check("postrst_done", done, 0);
      rst = 1'b0;
      run_feed("afterrst", 4, -1, -1, 0, 0, -1, -1, -1, 19, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
